hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-pipeline hazard logic.
- Tracks per-register result latency with countdown counters, so the stall decision is independent of the pipeline depth. Sources are `lw` at any stage depth, multi-cycle multiply/divide, and HI/LO moves.
- Sits in the decode stage. Its `stall` output gates PC/IF write and injects a bubble into execute.
- Includes a multiply/divide busy counter, replacing the external `busy` input.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is never tracked.
- RA_W, 5, register address width (log2 NREG).
- LAT_W, 4, width of each latency counter.
- MUL_LAT, 5, cycles from accepted `mult`/`multu` until HI/LO readable.
- DIV_LAT, 10, cycles from accepted `div`/`divu` until HI/LO readable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode holds a valid instruction
- rs_addr  in  RA_W  source register 1
- rs_used  in  1  instruction reads rs
- rt_addr  in  RA_W  source register 2
- rt_used  in  1  instruction reads rt; equivalent to `rtvalid`, and is 0 for store data, which is forwarded at M
- rd_we  in  1  instruction writes a GPR
- rd_addr  in  RA_W  destination register
- rd_lat  in  LAT_W  cycles after issue until the result is forwardable; 0 means available next cycle
- md_start  in  1  mult/div start
- md_div  in  1  1 = divide latency, 0 = multiply latency
- md_use  in  1  mfhi/mflo/mthi/mtlo
- flush  in  1  squash the decode instruction this cycle
- stall  out  1  hold decode/IF, insert bubble
- accept  out  1  instruction issues this cycle
- md_busy  out  1  multiply/divide counter nonzero
- pending  out  NREG  bit i = cnt[i] != 0; bit 0 is always 0

Behaviour:
- **State:**
  - cnt[1..NREG-1], each LAT_W bits.
  - md_cnt, wide enough for max(MUL_LAT, DIV_LAT).
- **Reset:** all cnt = 0 and md_cnt = 0. Outputs are therefore stall = 0, accept = 0 when issue_valid = 0, md_busy = 0, pending = 0.
- **stall (combinational):** stall = issue_valid & ~flush & (raw | mdh), where
  - raw = (rs_used & rs_addr != 0 & cnt[rs_addr] != 0) | (rt_used & rt_addr != 0 & cnt[rt_addr] != 0)
  - mdh = (md_use | md_start) & md_cnt != 0
- **WAW:** if rd_we and cnt[rd_addr] > rd_lat, stall as well. This prevents an older long-latency write from overtaking a newer one.
- **accept:** accept = issue_valid & ~flush & ~stall.
- **Per-cycle update, each register i:**
  - if accept & rd_we & rd_addr == i & i != 0, then cnt[i] <= rd_lat (the load overrides the decrement);
  - else if cnt[i] != 0, then cnt[i] <= cnt[i] - 1 (saturates at 0).
- **md_cnt update:**
  - if accept & md_start, then md_cnt <= (md_div ? DIV_LAT : MUL_LAT);
  - else decrement, saturating at 0.
  - md_busy = (md_cnt != 0), registered-state derived, no combinational path from inputs.
- **Boundary conditions:**
  - **flush:** forces stall = 0 and accept = 0. It does not clear cnt, because older in-flight producers remain valid.
  - **rd_addr = 0:** never loads a counter; a source of register 0 never stalls.
  - **Counter reaching 1:** the stall is released in the cycle the counter reads 1 → 0. The consumer issues the cycle after it reads 0, i.e. rd_lat + 1 cycles after the producer's accept when back-to-back.
  - **rd_lat = 0:** no stall for a dependent instruction in the next cycle (pure ALU forward).
  - **Same register as source and destination:** the stall is evaluated on old cnt. The load applies only on accept.
  - **md_start while md_busy:** stalls. md_use while md_busy: stalls. md_start with md_use both set: treated as md_start.
  - **reset mid-operation:** all counters go to 0 on the next edge regardless of other inputs, and reset dominates accept.
  - **rd_lat is not clamped:** the producer must encode it within LAT_W.

Decomposition:
- **Shared package `cpu_pkg`:**
  - RA_W, NREG;
  - latency constants LAT_ALU = 0, LAT_LOAD = 1;
  - MUL_LAT and DIV_LAT defaults.
- **Sub-module `lat_counter`:** one instance per register and one for md. It provides a load/decrement-saturate counter with a nonzero flag and is generated NREG-1 times plus once for md.

Test Plan:
1. Reset, then `lw` r8 (rd_lat = 1) accepted at cycle 0, dependent `add` rs = r8 presented at cycle 1 → stall = 1 at cycle 1, stall = 0 and accept = 1 at cycle 2; pending[8] = 1 only during cycle 1.
2. `add` r9 (rd_lat = 0) then `sub` rt = r9 back-to-back → no stall; a `sw` using r8 as store data with rt_used = 0 after an `lw` r8 → no stall.
3. `div` accepted (DIV_LAT = 10), then `mflo` every cycle → stall for cycles 1..10, accept at cycle 11; md_busy falls after cycle 10. Repeat with `mult` → accept at cycle 6.
4. Producer writes r0 with rd_lat = 5, consumer reads r0 → never stalls, pending[0] = 0.
5. flush asserted with a hazardous instruction present → stall = 0, accept = 0, cnt unchanged; the instruction re-presented next cycle still stalls correctly.
6. Load r5 with rd_lat = 3, assert reset at cycle 1, then a consumer of r5 at cycle 2 → stall = 0; all pending bits 0 after the reset edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and result-latency defaults
// used by the decode-stage hazard scoreboard.
package cpu_pkg;

  localparam int NREG     = 32;
  localparam int RA_W     = 5;
  localparam int LAT_W    = 4;

  // Latency encodings as seen by rd_lat: cycles after issue until forwardable.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  localparam int MUL_LAT  = 5;
  localparam int DIV_LAT  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Smallest width that can hold the value v.
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Load / decrement-saturate countdown counter with a registered-state nonzero
// flag. One instance per tracked GPR plus one for the multiply/divide unit.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_nz
);

  logic [W-1:0] r_cnt;

  // A load wins over the decrement so a fresh producer restarts the countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register result countdowns plus a
// multiply/divide busy counter decide whether the decode instruction issues.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG    = cpu_pkg::NREG,
  parameter int RA_W    = cpu_pkg::RA_W,
  parameter int LAT_W   = cpu_pkg::LAT_W,
  parameter int MUL_LAT = cpu_pkg::MUL_LAT,
  parameter int DIV_LAT = cpu_pkg::DIV_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  rs_addr,
  input  logic             rs_used,
  input  logic [RA_W-1:0]  rt_addr,
  input  logic             rt_used,
  input  logic             rd_we,
  input  logic [RA_W-1:0]  rd_addr,
  input  logic [LAT_W-1:0] rd_lat,
  input  logic             md_start,
  input  logic             md_div,
  input  logic             md_use,
  input  logic             flush,
  output logic             stall,
  output logic             accept,
  output logic             md_busy,
  output logic [NREG-1:0]  pending
);

  localparam int MD_W = width_for(max_int(MUL_LAT, DIV_LAT));
  localparam logic [MD_W-1:0] MD_MUL_VAL = MD_W'(MUL_LAT);
  localparam logic [MD_W-1:0] MD_DIV_VAL = MD_W'(DIV_LAT);

  logic [LAT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_nz;
  logic [MD_W-1:0]  w_md_cnt;
  logic             w_md_nz;
  logic             w_md_load;
  logic [MD_W-1:0]  w_md_load_val;

  logic             w_live;
  logic             w_rs_haz;
  logic             w_rt_haz;
  logic             w_raw;
  logic             w_mdh;
  logic             w_waw;
  logic             w_stall;
  logic             w_accept;

  // Register 0 is hardwired: never pending, never stalls a reader.
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    logic w_load;
    assign w_load = w_accept & rd_we & (rd_addr == RA_W'(gi));

    lat_counter #(
      .W(LAT_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_load_val(rd_lat),
      .o_cnt     (w_cnt[gi]),
      .o_nz      (w_nz[gi])
    );
  end

  assign w_md_load     = w_accept & md_start;
  assign w_md_load_val = md_div ? MD_DIV_VAL : MD_MUL_VAL;

  lat_counter #(
    .W(MD_W)
  ) u_md_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_md_load),
    .i_load_val(w_md_load_val),
    .o_cnt     (w_md_cnt),
    .o_nz      (w_md_nz)
  );

  // Hazards are judged on the current (old) counters; a same-register
  // source/destination only reloads its counter once the instruction issues.
  assign w_live   = issue_valid & ~flush;
  assign w_rs_haz = rs_used & (rs_addr != '0) & (w_cnt[rs_addr] != '0);
  assign w_rt_haz = rt_used & (rt_addr != '0) & (w_cnt[rt_addr] != '0);
  assign w_raw    = w_rs_haz | w_rt_haz;
  assign w_mdh    = (md_use | md_start) & (w_md_cnt != '0);
  // An older, slower write to the same register must not land after this one.
  assign w_waw    = rd_we & (w_cnt[rd_addr] > rd_lat);

  assign w_stall  = w_live & (w_raw | w_mdh | w_waw);
  assign w_accept = w_live & ~w_stall;

  assign stall   = w_stall;
  assign accept  = w_accept;
  assign md_busy = w_md_nz;
  assign pending = w_nz;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared against a timestamp-based readiness model.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int MUL_L = 5;
  localparam int DIV_L = 10;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  rs_addr;
  logic        rs_used;
  logic [4:0]  rt_addr;
  logic        rt_used;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_lat;
  logic        md_start;
  logic        md_div;
  logic        md_use;
  logic        flush;
  logic        stall;
  logic        accept;
  logic        md_busy;
  logic [31:0] pending;

  int n_checks;
  int n_errors;

  // Model: the first cycle number at which each result is ready (cnt == 0).
  int ready_at [NREG];
  int md_ready;
  int cyc;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .rs_addr    (rs_addr),
    .rs_used    (rs_used),
    .rt_addr    (rt_addr),
    .rt_used    (rt_used),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_lat     (rd_lat),
    .md_start   (md_start),
    .md_div     (md_div),
    .md_use     (md_use),
    .flush      (flush),
    .stall      (stall),
    .accept     (accept),
    .md_busy    (md_busy),
    .pending    (pending)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic logic exp_stall();
    logic raw, mdh, waw;
    raw = (rs_used && remaining(int'(rs_addr)) > 0) || (rt_used && remaining(int'(rt_addr)) > 0);
    mdh = (md_use || md_start) && (md_ready > cyc);
    waw = rd_we && (remaining(int'(rd_addr)) > int'(rd_lat));
    return issue_valid && !flush && (raw || mdh || waw);
  endfunction

  function automatic logic exp_accept();
    return issue_valid && !flush && !exp_stall();
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < NREG; r++) p[r] = (ready_at[r] > cyc);
    return p;
  endfunction

  task automatic model_check();
    check_val("stall",   {31'b0, stall},   {31'b0, exp_stall()});
    check_val("accept",  {31'b0, accept},  {31'b0, exp_accept()});
    check_val("md_busy", {31'b0, md_busy}, {31'b0, (md_ready > cyc)});
    check_val("pending", pending, exp_pending());
  endtask

  task automatic model_update();
    if (reset) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      md_ready = 0;
    end else if (exp_accept()) begin
      if (rd_we && rd_addr != 0) ready_at[rd_addr] = cyc + 1 + int'(rd_lat);
      if (md_start) md_ready = cyc + 1 + (md_div ? DIV_L : MUL_L);
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input int rs, input logic rsu, input int rt, input logic rtu,
                       input logic we, input int rd, input int lat,
                       input logic mds, input logic mdd, input logic mdu,
                       input logic fl, input logic rst);
    issue_valid = iv;
    rs_addr = 5'(rs);  rs_used = rsu;
    rt_addr = 5'(rt);  rt_used = rtu;
    rd_we = we;        rd_addr = 5'(rd);  rd_lat = 4'(lat);
    md_start = mds;    md_div = mdd;      md_use = mdu;
    flush = fl;        reset = rst;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    model_check();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive_idle();
      cyc_begin();
      cyc_end();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    md_ready = 0;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;

    // Reset: counters are unknown until the first edge, so no checks before it.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive_idle();
    cyc = 0;

    @(negedge clk);
    check_val("rst_stall",   {31'b0, stall},   32'd0);
    check_val("rst_accept",  {31'b0, accept},  32'd0);
    check_val("rst_md_busy", {31'b0, md_busy}, 32'd0);
    check_val("rst_pending", pending, 32'd0);
    cyc_end();

    // 1: lw r8 then dependent add.
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0);
    cyc_begin(); check_val("t1_lw_accept", {31'b0, accept}, 32'd1); cyc_end();
    drive(1, 8, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
    cyc_begin();
    check_val("t1_stall_c1", {31'b0, stall}, 32'd1);
    check_val("t1_pend8_c1", {31'b0, pending[8]}, 32'd1);
    cyc_end();
    cyc_begin();
    check_val("t1_stall_c2",  {31'b0, stall},  32'd0);
    check_val("t1_accept_c2", {31'b0, accept}, 32'd1);
    check_val("t1_pend8_c2",  {31'b0, pending[8]}, 32'd0);
    cyc_end();

    // 2: ALU forward and store data not tracked.
    drive(1, 0, 0, 9, 1, 1, 10, 0, 0, 0, 0, 0, 0);
    cyc_begin(); check_val("t2_alu_fwd", {31'b0, stall}, 32'd0); cyc_end();
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0);
    cyc_begin(); cyc_end();
    drive(1, 2, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_begin(); check_val("t2_sw_nostall", {31'b0, stall}, 32'd0); cyc_end();

    // 3: div then mflo every cycle; then mult.
    for (int m = 0; m < 2; m++) begin
      int lat_md;
      lat_md = (m == 0) ? DIV_L : MUL_L;
      idle_cycles(2);
      drive(1, 4, 1, 5, 1, 0, 0, 0, 1, (m == 0), 0, 0, 0);
      cyc_begin(); check_val("t3_md_accept", {31'b0, accept}, 32'd1); cyc_end();
      drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= lat_md; k++) begin
        cyc_begin();
        check_val("t3_mf_stall", {31'b0, stall}, 32'd1);
        check_val("t3_md_busy",  {31'b0, md_busy}, 32'd1);
        cyc_end();
      end
      cyc_begin();
      check_val("t3_mf_accept", {31'b0, accept}, 32'd1);
      check_val("t3_md_idle",   {31'b0, md_busy}, 32'd0);
      cyc_end();
    end

    // 4: register 0 is never tracked.
    drive(1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    cyc_begin(); cyc_end();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_begin();
    check_val("t4_r0_stall", {31'b0, stall}, 32'd0);
    check_val("t4_pend0",    {31'b0, pending[0]}, 32'd0);
    cyc_end();

    // 5: flush over a hazard, then re-present.
    idle_cycles(2);
    drive(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0);
    cyc_begin(); cyc_end();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc_begin();
    check_val("t5_fl_stall",  {31'b0, stall},  32'd0);
    check_val("t5_fl_accept", {31'b0, accept}, 32'd0);
    check_val("t5_fl_pend3",  {31'b0, pending[3]}, 32'd1);
    cyc_end();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_begin(); check_val("t5_re_stall", {31'b0, stall}, 32'd1); cyc_end();
    cyc_begin(); check_val("t5_re_accept", {31'b0, accept}, 32'd1); cyc_end();

    // 6: reset mid-operation.
    drive(1, 0, 0, 0, 0, 1, 5, 3, 1, 1, 0, 0, 0);
    cyc_begin(); cyc_end();
    drive(1, 0, 0, 0, 0, 1, 7, 9, 0, 0, 0, 0, 1);
    cyc_begin(); cyc_end();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_begin();
    check_val("t6_stall",   {31'b0, stall},   32'd0);
    check_val("t6_pending", pending, 32'd0);
    check_val("t6_md_busy", {31'b0, md_busy}, 32'd0);
    cyc_end();

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      int lat_r;
      lat_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      drive($urandom_range(0, 7) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)), lat_r,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      cyc_begin();
      cyc_end();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
